// File: rtl/riscv_v_mul_ctrl.sv
// riscv_v_mul_ctrl: sequences one packed-vector multiply through a shared
// MUL_WIDTH-bit vedic multiplier, one MUL_WIDTH chunk per cycle, and
// gathers the per-element low or high product halves into resp_data.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_a, req_b                    packed vector sources (DATA_WIDTH)
//   req_osize                       one-hot element size: bit0=8 .. bit3=64
//   req_signed, req_high            signed multiply, return upper half
//   kill                            abort the in-flight operation
//   mul_a, mul_b, mul_is_signed,
//   mul_osize                       registered multiplier drive
//   mul_z                           multiplier result, MUL_LATENCY cycles later
//   resp_valid/resp_ready           response handshake
//   resp_data, resp_err             result vector, unsupported-size flag
//   perf_ops                        completed good ops
//
// Build option: define RISCV_V_MUL_CTRL_PERF_EN to enable the perf_ops
// counter; otherwise perf_ops is tied to zero.

package riscv_v_mul_ctrl_pkg;
  localparam int unsigned OSIZE_W = 4;
  // One-hot element size: bit0=8, bit1=16, bit2=32, bit3=64 bits
  typedef logic [OSIZE_W-1:0] osize_vector_t;
endpackage

module riscv_v_mul_ctrl
  import riscv_v_mul_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned MUL_WIDTH   = 32,
  parameter int unsigned MUL_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_WIDTH-1:0]  req_a,
  input  logic [DATA_WIDTH-1:0]  req_b,
  input  osize_vector_t          req_osize,
  input  logic                   req_signed,
  input  logic                   req_high,
  input  logic                   kill,
  output logic [MUL_WIDTH-1:0]   mul_a,
  output logic [MUL_WIDTH-1:0]   mul_b,
  output logic                   mul_is_signed,
  output osize_vector_t          mul_osize,
  input  logic [2*MUL_WIDTH-1:0] mul_z,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   resp_err,
  output logic [31:0]            perf_ops
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / MUL_WIDTH;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    high_q, high_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    iss_v_q, iss_v_d;
  logic [IDX_W-1:0]        iss_idx_q, iss_idx_d;
  logic [MUL_WIDTH-1:0]    mul_a_d, mul_b_d;
  logic                    sgn_d;
  osize_vector_t           os_d;
  logic                    resp_err_d;
  logic [DATA_WIDTH-1:0]   resp_data_d;
  logic                    size_err_c;
  logic                    accept_c;
  logic                    kill_c;
  logic                    cap_v;
  logic [IDX_W-1:0]        cap_idx;
  logic [MUL_WIDTH-1:0]    ext_c [4];
  logic [MUL_WIDTH-1:0]    chunk_res;

  assign accept_c = (state_q == S_IDLE) && req_valid && req_ready;
  assign kill_c   = kill && (state_q != S_IDLE);

  // Element sizes wider than the multiplier cannot be split across chunks
  assign size_err_c = (req_osize[3] && (MUL_WIDTH < 64)) ||
                      (req_osize[2] && (MUL_WIDTH < 32)) ||
                      (req_osize[1] && (MUL_WIDTH < 16));

  // Per-size selection of the low/high half of each 2E-bit element product
  for (genvar s = 0; s < 4; s++) begin : g_size
    localparam int unsigned ELEM_W = 8 << s;
    if (ELEM_W <= MUL_WIDTH) begin : g_fit
      logic [MUL_WIDTH-1:0] res;
      always_comb begin
        res = '0;
        for (int i = 0; i < MUL_WIDTH / ELEM_W; i++) begin
          res[ELEM_W*i +: ELEM_W] = high_q ? mul_z[2*ELEM_W*i+ELEM_W +: ELEM_W]
                                           : mul_z[2*ELEM_W*i +: ELEM_W];
        end
      end
      assign ext_c[s] = res;
    end else begin : g_wide
      assign ext_c[s] = '0;
    end
  end

  // One-hot size mux of the captured chunk
  always_comb begin
    chunk_res = '0;
    for (int s = 0; s < 4; s++) begin
      if (mul_osize[s]) chunk_res = chunk_res | ext_c[s];
    end
  end

  // Valid/index shift line aligning each issue with its multiplier result
  if (MUL_LATENCY == 0) begin : g_nolat
    assign cap_v   = iss_v_q;
    assign cap_idx = iss_idx_q;
  end else begin : g_lat
    logic [MUL_LATENCY-1:0]            pv_q;
    logic [MUL_LATENCY-1:0][IDX_W-1:0] pi_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        pi_q <= '0;
      end else if (kill_c) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= iss_v_q;
        pi_q[0] <= iss_idx_q;
        for (int j = 1; j < MUL_LATENCY; j++) begin
          pv_q[j] <= pv_q[j-1];
          pi_q[j] <= pi_q[j-1];
        end
      end
    end
    assign cap_v   = pv_q[MUL_LATENCY-1];
    assign cap_idx = pi_q[MUL_LATENCY-1];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    high_d      = high_q;
    os_d        = mul_osize;
    sgn_d       = mul_is_signed;
    cnt_d       = cnt_q;
    iss_v_d     = 1'b0;
    iss_idx_d   = iss_idx_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    resp_err_d  = resp_err;
    resp_data_d = resp_data;

    if (cap_v) resp_data_d[32'(cap_idx)*MUL_WIDTH +: MUL_WIDTH] = chunk_res;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          a_d         = req_a;
          b_d         = req_b;
          high_d      = req_high;
          os_d        = req_osize;
          sgn_d       = req_signed;
          resp_data_d = '0;
          if (size_err_c) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            resp_err_d = 1'b0;
            mul_a_d    = req_a[MUL_WIDTH-1:0];
            mul_b_d    = req_b[MUL_WIDTH-1:0];
            iss_v_d    = 1'b1;
            iss_idx_d  = '0;
            cnt_d      = CNT_W'(1);
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // cnt_q is the next chunk to issue; the previous one is on the bus
        if (cnt_q < CNT_W'(NUM_CHUNKS)) begin
          mul_a_d   = a_q[32'(cnt_q)*MUL_WIDTH +: MUL_WIDTH];
          mul_b_d   = b_q[32'(cnt_q)*MUL_WIDTH +: MUL_WIDTH];
          iss_v_d   = 1'b1;
          iss_idx_d = IDX_W'(cnt_q);
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          state_d = (MUL_LATENCY == 0) ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cap_v && (cap_idx == IDX_W'(NUM_CHUNKS - 1))) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill_c) begin
      state_d = S_IDLE;
      iss_v_d = 1'b0;
      mul_a_d = '0;
      mul_b_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      high_q        <= 1'b0;
      cnt_q         <= '0;
      iss_v_q       <= 1'b0;
      iss_idx_q     <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_is_signed <= 1'b0;
      mul_osize     <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_data     <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      high_q        <= high_d;
      cnt_q         <= cnt_d;
      iss_v_q       <= iss_v_d;
      iss_idx_q     <= iss_idx_d;
      mul_a         <= mul_a_d;
      mul_b         <= mul_b_d;
      mul_is_signed <= sgn_d;
      mul_osize     <= os_d;
      req_ready     <= (state_d == S_IDLE);
      resp_valid    <= (state_d == S_RESP);
      resp_err      <= resp_err_d;
      resp_data     <= resp_data_d;
    end
  end

`ifdef RISCV_V_MUL_CTRL_PERF_EN
  // Counts completed good responses; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops <= '0;
    end else if ((state_q == S_RESP) && resp_ready && !resp_err) begin
      perf_ops <= perf_ops + 32'd1;
    end
  end
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_riscv_v_mul_ctrl.sv
// Self-checking bench for riscv_v_mul_ctrl: one instance with a combinational
// multiplier (MUL_LATENCY=0) and one with a 2-cycle multiplier, each fed by a
// behavioural multiplier model; expected results come from a full-width
// element-wise reference and go through a scoreboard queue.
module tb_riscv_v_mul_ctrl;
  import riscv_v_mul_ctrl_pkg::*;

  localparam int unsigned DW = 128;
  localparam int unsigned MW = 32;
  localparam osize_vector_t OS8  = 4'b0001;
  localparam osize_vector_t OS16 = 4'b0010;
  localparam osize_vector_t OS32 = 4'b0100;
  localparam osize_vector_t OS64 = 4'b1000;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          req_valid = 1'b0, req_signed = 1'b0, req_high = 1'b0;
  logic          kill = 1'b0, resp_ready = 1'b0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  osize_vector_t req_osize = '0;

  logic            rr0, rv0, re0, sg0, rr1, rv1, re1, sg1;
  logic [DW-1:0]   rd0, rd1;
  logic [MW-1:0]   ma0, mb0, ma1, mb1;
  osize_vector_t   mo0, mo1;
  logic [2*MW-1:0] mz0, mz1;
  logic [31:0]     po0, po1;

  // Two-stage delay for the latency-2 multiplier model
  logic [MW-1:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;
  osize_vector_t po1s = '0, po2s = '0;
  logic          ps1 = 1'b0, ps2 = 1'b0;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   good0 = 0, good1 = 0;

  riscv_v_mul_ctrl #(.DATA_WIDTH(DW), .MUL_WIDTH(MW), .MUL_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(rr0),
    .req_a(req_a), .req_b(req_b), .req_osize(req_osize),
    .req_signed(req_signed), .req_high(req_high), .kill(kill && !sel),
    .mul_a(ma0), .mul_b(mb0), .mul_is_signed(sg0), .mul_osize(mo0), .mul_z(mz0),
    .resp_valid(rv0), .resp_ready(resp_ready && !sel),
    .resp_data(rd0), .resp_err(re0), .perf_ops(po0)
  );

  riscv_v_mul_ctrl #(.DATA_WIDTH(DW), .MUL_WIDTH(MW), .MUL_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(rr1),
    .req_a(req_a), .req_b(req_b), .req_osize(req_osize),
    .req_signed(req_signed), .req_high(req_high), .kill(kill && sel),
    .mul_a(ma1), .mul_b(mb1), .mul_is_signed(sg1), .mul_osize(mo1), .mul_z(mz1),
    .resp_valid(rv1), .resp_ready(resp_ready && sel),
    .resp_data(rd1), .resp_err(re1), .perf_ops(po1)
  );

  // Element width in bits for a one-hot size (0 if no size selected)
  function automatic int unsigned elem_w(input osize_vector_t os);
    if (os[0]) return 8;
    if (os[1]) return 16;
    if (os[2]) return 32;
    if (os[3]) return 64;
    return 0;
  endfunction

  // Sign- or zero-extended element i of width e from a 128-bit vector
  function automatic logic [127:0] elem(input logic [127:0] v, input int unsigned e,
                                        input int i, input logic sgn);
    logic [127:0] m, x;
    m = (128'd1 << e) - 128'd1;
    x = (v >> (e * i)) & m;
    if (sgn && x[e-1]) x = x | ~m;
    return x;
  endfunction

  // Behavioural vedic multiplier: full 2E-bit products packed per element
  function automatic logic [2*MW-1:0] mul_model(input logic [MW-1:0] a, b,
                                                input osize_vector_t os, input logic sgn);
    logic [127:0] p, m2, z;
    int unsigned  e;
    e = elem_w(os);
    z = '0;
    if (e != 0 && e <= MW) begin
      m2 = (128'd1 << (2 * e)) - 128'd1;
      for (int i = 0; i < int'(MW / e); i++) begin
        p = elem(128'(a), e, i, sgn) * elem(128'(b), e, i, sgn);
        z = z | ((p & m2) << (2 * e * i));
      end
    end
    return (2*MW)'(z);
  endfunction

  // Reference result over the whole vector
  function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] a, b, input osize_vector_t os,
                                           input logic sgn, input logic hi);
    logic [127:0] p, m, r;
    int unsigned  e;
    e = elem_w(os);
    r = '0;
    m = (128'd1 << e) - 128'd1;
    for (int i = 0; i < int'(DW / e); i++) begin
      p = elem(128'(a), e, i, sgn) * elem(128'(b), e, i, sgn);
      r = r | (((p >> (hi ? e : 0)) & m) << (e * i));
    end
    return DW'(r);
  endfunction

  assign mz0 = mul_model(ma0, mb0, mo0, sg0);
  assign mz1 = mul_model(pa2, pb2, po2s, ps2);

  always @(posedge clk) begin
    pa1 <= ma1; pa2 <= pa1;
    pb1 <= mb1; pb2 <= pb1;
    po1s <= mo1; po2s <= po1s;
    ps1 <= sg1; ps2 <= ps1;
  end

  // Views of the currently selected instance
  logic          v_req_ready, v_resp_valid, v_resp_err;
  logic [DW-1:0] v_resp_data;
  logic [MW-1:0] v_mul_a;
  assign v_req_ready  = sel ? rr1 : rr0;
  assign v_resp_valid = sel ? rv1 : rv0;
  assign v_resp_err   = sel ? re1 : re0;
  assign v_resp_data  = sel ? rd1 : rd0;
  assign v_mul_a      = sel ? ma1 : ma0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one op on the selected instance; called and returns at a negedge
  task automatic run_op(input logic [DW-1:0] a, b, input osize_vector_t os,
                        input logic sgn, hi, input int hold, exp_lat,
                        input logic kill_idle);
    int   n;
    logic mul_seen, err;
    exp_t ex;
    err = os[3] && (MW < 64);
    req_a = a; req_b = b; req_osize = os; req_signed = sgn; req_high = hi;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    n = 0;
    while (!v_req_ready && n < 20) begin @(negedge clk); n++; end
    if (!v_req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    kill = kill_idle;
    ex.d = err ? '0 : ref_op(a, b, os, sgn, hi);
    ex.e = err;
    sb.push_back(ex);
    @(negedge clk);
    req_valid = 1'b0;
    kill = 1'b0;
    n = 1;
    mul_seen = 1'b0;
    while (!v_resp_valid && n < 40) begin
      mul_seen = mul_seen | (v_mul_a != '0);
      @(negedge clk);
      n++;
    end
    mul_seen = mul_seen | (v_mul_a != '0);
    if (!v_resp_valid) begin
      chk("resp_timeout", 0, 1);
      void'(sb.pop_front());
      kill = 1'b1; @(negedge clk); kill = 1'b0;
      resp_ready = 1'b0;
      return;
    end
    chk("resp_latency", DW'(n), DW'(exp_lat));
    if (err) chk("err_no_mul_activity", DW'(mul_seen), 0);
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", DW'(v_resp_valid), 1);
      chk("hold_data", v_resp_data, sb[0].d);
      chk("hold_req_ready", DW'(v_req_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    ex = sb.pop_front();
    chk("resp_data", v_resp_data, ex.d);
    chk("resp_err", DW'(v_resp_err), DW'(ex.e));
    chk("hs_req_ready", DW'(v_req_ready), 0);
    if (!ex.e) begin
      if (sel) good1++; else good0++;
    end
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_req_ready", DW'(v_req_ready), 1);
    chk("post_resp_valid", DW'(v_resp_valid), 0);
    chk("post_mul_a", DW'(v_mul_a), 0);
  endtask

  // Starts an op and kills it in cycle kcyc after accept
  task automatic kill_op(input logic [DW-1:0] a, b, input osize_vector_t os, input int kcyc);
    int   n;
    logic seen;
    req_a = a; req_b = b; req_osize = os; req_signed = 1'b0; req_high = 1'b0;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    n = 0;
    while (!v_req_ready && n < 20) begin @(negedge clk); n++; end
    chk("kill_accept", DW'(v_req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < kcyc; c++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_req_ready", DW'(v_req_ready), 1);
    chk("kill_resp_valid", DW'(v_resp_valid), 0);
    chk("kill_mul_a", DW'(v_mul_a), 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | v_resp_valid;
      @(negedge clk);
    end
    chk("kill_no_resp", DW'(seen), 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ra, rb;
    logic [31:0]   exp_p0, exp_p1;
    logic          seen;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", DW'(rr0), 0);
    chk("rst_resp_valid", DW'(rv0), 0);
    chk("rst_resp_err", DW'(re0), 0);
    chk("rst_resp_data", rd0, 0);
    chk("rst_mul_a", DW'(ma0), 0);
    chk("rst_mul_b", DW'(mb0), 0);
    chk("rst_mul_signed", DW'(sg0), 0);
    chk("rst_mul_osize", DW'(mo0), 0);
    chk("rst_perf", DW'(po0), 0);
    chk("rst_req_ready1", DW'(rr1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_req_ready", DW'(rr0), 1);
    chk("rst_rel_req_ready1", DW'(rr1), 1);

    // Combinational multiplier instance
    sel = 1'b0;
    run_op({4{32'h0000_0003}}, {4{32'h0000_0003}}, OS32, 1'b0, 1'b0, 0, 5, 1'b0);
    run_op({16{8'h80}}, {16{8'h80}}, OS8, 1'b1, 1'b1, 0, 5, 1'b0);
    run_op({4{32'h1234_5678}}, {4{32'h8765_4321}}, OS64, 1'b0, 1'b0, 0, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(ra, rb, osize_vector_t'(4'b0001 << (k % 3)), k[0], k[1], k % 2, 5, 1'b0);
    end
    run_op({8{16'hFFFF}}, {8{16'h7FFF}}, OS16, 1'b1, 1'b1, 1, 5, 1'b1);
    kill_op({4{32'hDEAD_BEEF}}, {4{32'h0BAD_F00D}}, OS32, 2);
    run_op({4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, OS32, 1'b0, 1'b1, 0, 5, 1'b0);

    // Two-cycle multiplier instance
    sel = 1'b1;
    run_op({4{32'h0000_0003}}, {4{32'h0000_0003}}, OS32, 1'b0, 1'b0, 3, 7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(ra, rb, osize_vector_t'(4'b0001 << k), ~k[0], k[0], 0, 7, 1'b0);
    end
    run_op({4{32'h5555_5555}}, {4{32'h5555_5555}}, OS64, 1'b1, 1'b0, 2, 1, 1'b0);
    kill_op({4{32'h0102_0304}}, {4{32'h0506_0708}}, OS16, 6);
    run_op({16{8'h7F}}, {16{8'h81}}, OS8, 1'b1, 1'b0, 0, 7, 1'b0);

`ifdef RISCV_V_MUL_CTRL_PERF_EN
    exp_p0 = 32'(good0);
    exp_p1 = 32'(good1);
`else
    exp_p0 = 32'd0;
    exp_p1 = 32'd0;
`endif
    chk("perf_ops0", DW'(po0), DW'(exp_p0));
    chk("perf_ops1", DW'(po1), DW'(exp_p1));

    // Reset in the middle of an operation discards it
    sel = 1'b0;
    req_a = {4{32'h0000_0007}}; req_b = {4{32'h0000_0005}};
    req_osize = OS32; req_signed = 1'b0; req_high = 1'b0;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", DW'(rr0), 0);
    chk("midrst_resp_valid", DW'(rv0), 0);
    chk("midrst_mul_a", DW'(ma0), 0);
    chk("midrst_perf", DW'(po0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", DW'(rr0), 1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | rv0;
      @(negedge clk);
    end
    chk("midrst_no_resp", DW'(seen), 0);
    resp_ready = 1'b0;
    run_op({8{16'h0003}}, {8{16'hFFFD}}, OS16, 1'b1, 1'b0, 0, 5, 1'b0);

    chk("sb_empty", DW'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
